multi_channel_memory: RTL and testbench
=======================================

// Module: multi_channel_memory
// PURPOSE
//  Parametrised behavioural data/program memory serving NUM_CHANNELS independent consumers (LSUs, fetchers).
//  Each channel has separate read and write request sides using valid/ready four-phase handshakes.
//  Each side has a programmable per-request latency.
//  Per-cycle array bandwidth is one read and one write, so round-robin arbitration is needed and queuing delay is visible.
// PARAMETERS
//  ADDR_BITS      8   address width; depth = 2**ADDR_BITS words
//  DATA_BITS      16  word width
//  NUM_CHANNELS   4   consumer channels (>=1)
//  READ_LATENCY   3   minimum wait cycles before a read may arbitrate (>=1)
//  WRITE_LATENCY  3   minimum wait cycles before a write may arbitrate (>=1)
// PORTS
//  clk                in   1                     clock, rising edge
//  reset              in   1                     asynchronous, active-high
//  mem_read_valid     in   NUM_CHANNELS          per-channel read request
//  mem_read_address   in   NUM_CHANNELS*ADDR_BITS  packed, channel c at [c*ADDR_BITS +: ADDR_BITS]
//  mem_read_ready     out  NUM_CHANNELS          read data valid / request done
//  mem_read_data      out  NUM_CHANNELS*DATA_BITS  packed read data
//  mem_write_valid    in   NUM_CHANNELS          per-channel write request
//  mem_write_address  in   NUM_CHANNELS*ADDR_BITS  packed
//  mem_write_data     in   NUM_CHANNELS*DATA_BITS  packed
//  mem_write_ready    out  NUM_CHANNELS          write committed
//  perf_reads         out  32                    (MEM_PERF_EN only) completed reads
//  perf_writes        out  32                    (MEM_PERF_EN only) completed writes
// BEHAVIOUR
//  Reset:
//   - all ready=0, read_data=0, every side FSM=IDLE, latency counters=0, perf counters=0.
//   - Array contents are NOT cleared.
//   - Reset mid-request aborts the request; a pending write is never committed.
//  Per side FSM, one per channel per direction:
//   - IDLE->WAIT: on valid; capture address (and data for writes).
//   - WAIT: counter increments each cycle until it reaches LATENCY, then raises arb request.
//   - WAIT->READY: when granted.
//     - Read: data <= mem[addr], ready <= 1.
//     - Write: mem[addr] <= data, ready <= 1.
//   - READY->IDLE: when valid is low; ready <= 0, counter <= 0.
//  Handshake rules:
//   - Consumer holds valid and operands stable until ready. Operands are sampled only on the IDLE edge.
//   - Ready stays high until valid drops. A new request needs one IDLE cycle, so valid must be low >=1 cycle.
//   - Uncontended latency: valid sampled at edge k -> ready visible after edge k+LATENCY+1.
//  Arbitration:
//   - Independent round-robin arbiters for reads and writes; at most one grant each per cycle.
//   - The pointer advances to (granted+1) mod NUM_CHANNELS; no grant -> pointer unchanged.
//   - The losing request stays in WAIT, flagged; no starvation: worst-case added delay is NUM_CHANNELS-1 cycles.
//  Hazards and boundaries:
//   - Read and write to the same address granted on the same edge: the read returns the OLD word.
//   - Two channels writing the same address: arbitration order decides; the last grant wins.
//   - Address range is full 2**ADDR_BITS, no wrap logic. Counter width is $clog2(max(LATENCY)+1).
//   - Read and write sides of one channel are fully independent and may be active together.
// CONFIGURATION
//  `define MEM_PERF_EN:
//   - Adds perf_reads and perf_writes ports; each increments on its grant.
//   - Each saturates at 32'hFFFF_FFFF and is cleared by reset.
//  Without it: the ports and counters are absent; function and timing are otherwise identical.
// STRUCTURE
//  memory_pkg:
//   - mem_state_t enum {IDLE=2'b00, WAITING=2'b10, READY=2'b11}.
//   - Default width localparams.
//   - Helper function clog2_min1.
//  Sub-module rr_arbiter #(N):
//   - Ports req[N], grant[N] one-hot, async-reset pointer.
//   - Instantiated twice: read and write.
// TESTING
//  1. 1 channel: write 0x1234 to addr 0x05, then read addr 0x05 -> write_ready after 4 edges, read_data=0x1234 after 4 edges.
//  2. 4 channels read simultaneously after reset -> ready order ch0,ch1,ch2,ch3 on consecutive cycles (edges 4..7).
//  3. Read and write to addr 0x10 (old 0xAAAA, new 0x5555) granted on the same edge -> read returns 0xAAAA; a later read returns 0x5555.
//  4. Consumer holds valid 10 cycles after ready -> ready stays 1 and data is stable; valid low -> ready 0 next edge; re-request succeeds.
//  5. Assert reset during WAIT of a write to 0x20 (old 0x0001) -> ready=0 immediately; a later read of 0x20 returns 0x0001.
//  6. MEM_PERF_EN: 3 reads and 2 writes complete -> perf_reads=3, perf_writes=2; reset -> 0.

Source files
------------

// File: rtl/memory_pkg.sv
// memory_pkg: shared types, default widths and sizing helper for multi_channel_memory.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package memory_pkg;

  // WAITING and READY share the top bit so "request outstanding" is state[1].
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WAITING = 2'b10,
    READY   = 2'b11
  } mem_state_t;

  localparam int DEF_ADDR_BITS     = 8;
  localparam int DEF_DATA_BITS     = 16;
  localparam int DEF_NUM_CHANNELS  = 4;
  localparam int DEF_READ_LATENCY  = 3;
  localparam int DEF_WRITE_LATENCY = 3;

  // $clog2 that never returns 0, so a one-entry range still gets a 1-bit vector.
  function automatic int clog2_min1(input int value);
    return (value < 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter, one-hot grant among N requesters.
// Latency: grant is combinational from req; pointer updates on the granting edge.
// Backpressure: a requester without grant keeps req high and is served within N-1 cycles.
// Ports: clk, reset (async, active-high), req[N] in, grant[N] out (one-hot or zero).
module rr_arbiter
  import memory_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PW = clog2_min1(N);

  logic [PW-1:0] ptr;
  logic          found;

  // First pass looks at indices at or above the pointer, second pass wraps to the bottom.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (PW'(i) >= ptr)) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (grant[i]) ptr <= PW'((i + 1) % N);
      end
    end
  end

endmodule

// File: rtl/multi_channel_memory.sv
// multi_channel_memory: behavioural word memory shared by NUM_CHANNELS consumers, one read + one write per cycle.
// Latency: ready LATENCY+1 edges after valid is sampled, plus up to NUM_CHANNELS-1 cycles of arbitration.
// Backpressure: consumer holds valid/operands until ready; ready holds until valid drops.
// Ports: clk, reset (async, active-high); per channel read valid/address -> ready/data,
//        write valid/address/data -> ready; all channel buses packed, channel c at [c*W +: W].
// Optional: `define MEM_PERF_EN adds perf_reads/perf_writes (saturating grant counters).
module multi_channel_memory
  import memory_pkg::*;
#(
  parameter int ADDR_BITS     = DEF_ADDR_BITS,
  parameter int DATA_BITS     = DEF_DATA_BITS,
  parameter int NUM_CHANNELS  = DEF_NUM_CHANNELS,
  parameter int READ_LATENCY  = DEF_READ_LATENCY,
  parameter int WRITE_LATENCY = DEF_WRITE_LATENCY
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CHANNELS-1:0]           mem_read_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_read_address,
  output logic [NUM_CHANNELS-1:0]           mem_read_ready,
  output logic [NUM_CHANNELS*DATA_BITS-1:0] mem_read_data,
  input  logic [NUM_CHANNELS-1:0]           mem_write_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_write_address,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_write_data,
  output logic [NUM_CHANNELS-1:0]           mem_write_ready
`ifdef MEM_PERF_EN
  ,
  output logic [31:0]                       perf_reads,
  output logic [31:0]                       perf_writes
`endif
);

  localparam int MAX_LAT  = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_BITS = clog2_min1(MAX_LAT + 1);
  localparam logic [CNT_BITS-1:0] RD_LAT = CNT_BITS'(READ_LATENCY);
  localparam logic [CNT_BITS-1:0] WR_LAT = CNT_BITS'(WRITE_LATENCY);

  // Array is deliberately not reset.
  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  mem_state_t            rd_state   [NUM_CHANNELS];
  mem_state_t            rd_state_nx[NUM_CHANNELS];
  logic [CNT_BITS-1:0]   rd_cnt     [NUM_CHANNELS];
  logic [CNT_BITS-1:0]   rd_cnt_nx  [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]  rd_addr    [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]  rd_addr_nx [NUM_CHANNELS];
  logic [DATA_BITS-1:0]  rd_data_q  [NUM_CHANNELS];
  logic [DATA_BITS-1:0]  rd_data_nx [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] rd_rdy_nx, rd_req, rd_gnt;

  mem_state_t            wr_state   [NUM_CHANNELS];
  mem_state_t            wr_state_nx[NUM_CHANNELS];
  logic [CNT_BITS-1:0]   wr_cnt     [NUM_CHANNELS];
  logic [CNT_BITS-1:0]   wr_cnt_nx  [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]  wr_addr    [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]  wr_addr_nx [NUM_CHANNELS];
  logic [DATA_BITS-1:0]  wr_data_q  [NUM_CHANNELS];
  logic [DATA_BITS-1:0]  wr_data_nx [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] wr_rdy_nx, wr_req, wr_gnt;

  // Requests depend only on registered state, keeping grant out of any comb loop.
  always_comb begin
    rd_req = '0;
    wr_req = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      rd_req[c] = (rd_state[c] == WAITING) && (rd_cnt[c] == RD_LAT);
      wr_req[c] = (wr_state[c] == WAITING) && (wr_cnt[c] == WR_LAT);
    end
  end

  rr_arbiter #(.N(NUM_CHANNELS)) u_rd_arb (.clk(clk), .reset(reset), .req(rd_req), .grant(rd_gnt));
  rr_arbiter #(.N(NUM_CHANNELS)) u_wr_arb (.clk(clk), .reset(reset), .req(wr_req), .grant(wr_gnt));

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      rd_state_nx[c] = rd_state[c];
      rd_cnt_nx[c]   = rd_cnt[c];
      rd_addr_nx[c]  = rd_addr[c];
      rd_data_nx[c]  = rd_data_q[c];
      rd_rdy_nx[c]   = mem_read_ready[c];
      case (rd_state[c])
        IDLE: if (mem_read_valid[c]) begin
          rd_state_nx[c] = WAITING;
          rd_cnt_nx[c]   = '0;
          rd_addr_nx[c]  = mem_read_address[c*ADDR_BITS +: ADDR_BITS];
        end
        WAITING: if (rd_cnt[c] != RD_LAT) begin
          rd_cnt_nx[c] = rd_cnt[c] + 1'b1;
        end else if (rd_gnt[c]) begin
          rd_state_nx[c] = READY;
          rd_rdy_nx[c]   = 1'b1;
          rd_data_nx[c]  = mem[rd_addr[c]];  // pre-edge contents: same-edge write is not seen
        end
        READY: if (!mem_read_valid[c]) begin
          rd_state_nx[c] = IDLE;
          rd_rdy_nx[c]   = 1'b0;
          rd_cnt_nx[c]   = '0;
        end
        default: rd_state_nx[c] = IDLE;
      endcase
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      wr_state_nx[c] = wr_state[c];
      wr_cnt_nx[c]   = wr_cnt[c];
      wr_addr_nx[c]  = wr_addr[c];
      wr_data_nx[c]  = wr_data_q[c];
      wr_rdy_nx[c]   = mem_write_ready[c];
      case (wr_state[c])
        IDLE: if (mem_write_valid[c]) begin
          wr_state_nx[c] = WAITING;
          wr_cnt_nx[c]   = '0;
          wr_addr_nx[c]  = mem_write_address[c*ADDR_BITS +: ADDR_BITS];
          wr_data_nx[c]  = mem_write_data[c*DATA_BITS +: DATA_BITS];
        end
        WAITING: if (wr_cnt[c] != WR_LAT) begin
          wr_cnt_nx[c] = wr_cnt[c] + 1'b1;
        end else if (wr_gnt[c]) begin
          wr_state_nx[c] = READY;
          wr_rdy_nx[c]   = 1'b1;
        end
        READY: if (!mem_write_valid[c]) begin
          wr_state_nx[c] = IDLE;
          wr_rdy_nx[c]   = 1'b0;
          wr_cnt_nx[c]   = '0;
        end
        default: wr_state_nx[c] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_read_ready  <= '0;
      mem_write_ready <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        rd_state[c]  <= IDLE;
        rd_cnt[c]    <= '0;
        rd_addr[c]   <= '0;
        rd_data_q[c] <= '0;
        wr_state[c]  <= IDLE;
        wr_cnt[c]    <= '0;
        wr_addr[c]   <= '0;
        wr_data_q[c] <= '0;
      end
    end else begin
      mem_read_ready  <= rd_rdy_nx;
      mem_write_ready <= wr_rdy_nx;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        rd_state[c]  <= rd_state_nx[c];
        rd_cnt[c]    <= rd_cnt_nx[c];
        rd_addr[c]   <= rd_addr_nx[c];
        rd_data_q[c] <= rd_data_nx[c];
        wr_state[c]  <= wr_state_nx[c];
        wr_cnt[c]    <= wr_cnt_nx[c];
        wr_addr[c]   <= wr_addr_nx[c];
        wr_data_q[c] <= wr_data_nx[c];
      end
    end
  end

  // Reset forces every side to IDLE asynchronously, so no grant (and no commit)
  // can occur on an edge while reset is high; no reset term is needed here.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (wr_gnt[c]) mem[wr_addr[c]] <= wr_data_q[c];
    end
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_rd_out
    assign mem_read_data[c*DATA_BITS +: DATA_BITS] = rd_data_q[c];
  end

`ifdef MEM_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_reads  <= '0;
      perf_writes <= '0;
    end else begin
      if (|rd_gnt && (perf_reads != 32'hFFFF_FFFF))  perf_reads  <= perf_reads + 32'd1;
      if (|wr_gnt && (perf_writes != 32'hFFFF_FFFF)) perf_writes <= perf_writes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multi_channel_memory.sv
module tb_multi_channel_memory;
  localparam int AB  = 8;
  localparam int DB  = 16;
  localparam int NCH = 4;
  localparam int RL  = 3;
  localparam int WL  = 3;

  logic clk = 1'b0;
  logic reset;
  logic [NCH-1:0]    mem_read_valid, mem_read_ready, mem_write_valid, mem_write_ready;
  logic [NCH*AB-1:0] mem_read_address, mem_write_address;
  logic [NCH*DB-1:0] mem_read_data, mem_write_data;
`ifdef MEM_PERF_EN
  logic [31:0] perf_reads, perf_writes;
`endif

  int passed = 0;
  int total  = 0;

  // Reference model: plain array updated in grant order.
  logic [DB-1:0] model_mem [256];
  bit            model_known [256];
  logic [AB-1:0] known_q [$];

  // One batch of requests, all presented on the same edge.
  bit            b_rd_en  [NCH];
  bit            b_wr_en  [NCH];
  logic [AB-1:0] b_rd_addr[NCH];
  logic [AB-1:0] b_wr_addr[NCH];
  logic [DB-1:0] b_wr_dat [NCH];
  logic [DB-1:0] b_rd_got [NCH];
  int            b_rd_lat [NCH];
  int            b_wr_lat [NCH];

  always #5 clk = ~clk;

  multi_channel_memory dut (
    .clk(clk), .reset(reset),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready)
`ifdef MEM_PERF_EN
    , .perf_reads(perf_reads), .perf_writes(perf_writes)
`endif
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mem_read_valid  = '0;
    mem_write_valid = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic clear_batch();
    for (int c = 0; c < NCH; c++) begin
      b_rd_en[c] = 1'b0; b_wr_en[c] = 1'b0;
      b_rd_addr[c] = '0; b_wr_addr[c] = '0; b_wr_dat[c] = '0;
    end
  endtask

  // Latency is counted in edges after the edge that samples valid.
  task automatic run_batch(input int budget);
    int edges;
    bit busy;
    for (int c = 0; c < NCH; c++) begin
      mem_read_valid[c] = b_rd_en[c];
      mem_read_address[c*AB +: AB] = b_rd_addr[c];
      mem_write_valid[c] = b_wr_en[c];
      mem_write_address[c*AB +: AB] = b_wr_addr[c];
      mem_write_data[c*DB +: DB] = b_wr_dat[c];
      b_rd_lat[c] = -1; b_wr_lat[c] = -1; b_rd_got[c] = '0;
    end
    edges = 0;
    busy = (|mem_read_valid) || (|mem_write_valid);
    while (busy && edges < budget) begin
      tick();
      edges++;
      for (int c = 0; c < NCH; c++) begin
        if (mem_read_valid[c] && mem_read_ready[c]) begin
          b_rd_lat[c] = edges - 1;
          b_rd_got[c] = mem_read_data[c*DB +: DB];
          mem_read_valid[c] = 1'b0;
        end
        if (mem_write_valid[c] && mem_write_ready[c]) begin
          b_wr_lat[c] = edges - 1;
          mem_write_valid[c] = 1'b0;
        end
      end
      busy = (|mem_read_valid) || (|mem_write_valid);
    end
    mem_read_valid  = '0;
    mem_write_valid = '0;
    tick();
  endtask

  // Writes land in grant order, so the latest grant to an address wins.
  task automatic commit_model();
    for (int t = 0; t < 64; t++) begin
      for (int c = 0; c < NCH; c++) begin
        if (b_wr_en[c] && b_wr_lat[c] == t) begin
          model_mem[b_wr_addr[c]] = b_wr_dat[c];
          if (!model_known[b_wr_addr[c]]) known_q.push_back(b_wr_addr[c]);
          model_known[b_wr_addr[c]] = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    mem_read_valid = '0; mem_write_valid = '0;
    mem_read_address = '0; mem_write_address = '0; mem_write_data = '0;
    reset = 1'b1;
    tick();
    tick();
    total++; if (mem_read_ready !== '0) $display("FAIL reset_read_ready got %b want 0", mem_read_ready); else passed++;
    total++; if (mem_write_ready !== '0) $display("FAIL reset_write_ready got %b want 0", mem_write_ready); else passed++;
    total++; if (mem_read_data !== '0) $display("FAIL reset_read_data got %h want 0", mem_read_data); else passed++;
`ifdef MEM_PERF_EN
    total++; if (perf_reads !== 32'd0 || perf_writes !== 32'd0)
      $display("FAIL reset_perf got %0d/%0d want 0/0", perf_reads, perf_writes); else passed++;
`endif
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_channel();
    clear_batch();
    b_wr_en[0] = 1'b1; b_wr_addr[0] = 8'h05; b_wr_dat[0] = 16'h1234;
    run_batch(30);
    total++; if (b_wr_lat[0] != WL + 1) $display("FAIL single_write_lat got %0d want %0d", b_wr_lat[0], WL + 1); else passed++;
    commit_model();
    clear_batch();
    b_rd_en[0] = 1'b1; b_rd_addr[0] = 8'h05;
    run_batch(30);
    total++; if (b_rd_lat[0] != RL + 1) $display("FAIL single_read_lat got %0d want %0d", b_rd_lat[0], RL + 1); else passed++;
    total++; if (b_rd_got[0] !== 16'h1234) $display("FAIL single_read_data got %h want 1234", b_rd_got[0]); else passed++;
  endtask

  task automatic test_parallel_reads();
    clear_batch();
    for (int c = 0; c < NCH; c++) begin
      b_wr_en[c] = 1'b1; b_wr_addr[c] = 8'(8'h40 + c); b_wr_dat[c] = 16'($urandom);
    end
    run_batch(40);
    commit_model();
    do_reset();
    clear_batch();
    for (int c = 0; c < NCH; c++) begin
      b_rd_en[c] = 1'b1; b_rd_addr[c] = 8'(8'h40 + c);
    end
    run_batch(40);
    for (int c = 0; c < NCH; c++) begin
      total++; if (b_rd_lat[c] != RL + 1 + c)
        $display("FAIL parallel_lat ch%0d got %0d want %0d", c, b_rd_lat[c], RL + 1 + c); else passed++;
      total++; if (b_rd_got[c] !== model_mem[b_rd_addr[c]])
        $display("FAIL parallel_data ch%0d got %h want %h", c, b_rd_got[c], model_mem[b_rd_addr[c]]); else passed++;
    end
  endtask

  task automatic test_rw_hazard();
    clear_batch();
    b_wr_en[3] = 1'b1; b_wr_addr[3] = 8'h10; b_wr_dat[3] = 16'hAAAA;
    run_batch(30);
    commit_model();
    clear_batch();
    b_rd_en[0] = 1'b1; b_rd_addr[0] = 8'h10;
    b_wr_en[1] = 1'b1; b_wr_addr[1] = 8'h10; b_wr_dat[1] = 16'h5555;
    run_batch(30);
    total++; if (b_rd_lat[0] != b_wr_lat[1] || b_rd_lat[0] != RL + 1)
      $display("FAIL hazard_same_edge got rd %0d wr %0d want both %0d", b_rd_lat[0], b_wr_lat[1], RL + 1); else passed++;
    total++; if (b_rd_got[0] !== 16'hAAAA) $display("FAIL hazard_old_word got %h want aaaa", b_rd_got[0]); else passed++;
    commit_model();
    clear_batch();
    b_rd_en[2] = 1'b1; b_rd_addr[2] = 8'h10;
    run_batch(30);
    total++; if (b_rd_got[2] !== 16'h5555) $display("FAIL hazard_new_word got %h want 5555", b_rd_got[2]); else passed++;
  endtask

  task automatic test_hold();
    int lat;
    logic [DB-1:0] want;
    want = model_mem[8'h10];
    mem_read_address[2*AB +: AB] = 8'h10;
    mem_read_valid[2] = 1'b1;
    lat = -1;
    for (int e = 1; e <= 20 && lat < 0; e++) begin
      tick();
      if (mem_read_ready[2]) lat = e - 1;
    end
    total++; if (lat != RL + 1) $display("FAIL hold_first_lat got %0d want %0d", lat, RL + 1); else passed++;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++; if (mem_read_ready[2] !== 1'b1) $display("FAIL hold_ready cyc%0d got %b want 1", i, mem_read_ready[2]); else passed++;
      total++; if (mem_read_data[2*DB +: DB] !== want)
        $display("FAIL hold_data cyc%0d got %h want %h", i, mem_read_data[2*DB +: DB], want); else passed++;
    end
    mem_read_valid[2] = 1'b0;
    tick();
    total++; if (mem_read_ready[2] !== 1'b0) $display("FAIL hold_release got %b want 0", mem_read_ready[2]); else passed++;
    clear_batch();
    b_rd_en[2] = 1'b1; b_rd_addr[2] = 8'h10;
    run_batch(30);
    total++; if (b_rd_lat[2] != RL + 1) $display("FAIL hold_rereq_lat got %0d want %0d", b_rd_lat[2], RL + 1); else passed++;
    total++; if (b_rd_got[2] !== want) $display("FAIL hold_rereq_data got %h want %h", b_rd_got[2], want); else passed++;
  endtask

  task automatic test_reset_abort();
    int lat;
    clear_batch();
    b_wr_en[0] = 1'b1; b_wr_addr[0] = 8'h20; b_wr_dat[0] = 16'h0001;
    run_batch(30);
    commit_model();
    // Channel 1 holds a completed read so reset has a live ready to clear.
    mem_read_address[1*AB +: AB] = 8'h20;
    mem_read_valid[1] = 1'b1;
    lat = -1;
    for (int e = 1; e <= 20 && lat < 0; e++) begin
      tick();
      if (mem_read_ready[1]) lat = e - 1;
    end
    total++; if (lat != RL + 1) $display("FAIL abort_pre_read_lat got %0d want %0d", lat, RL + 1); else passed++;
    mem_write_address[0 +: AB] = 8'h20;
    mem_write_data[0 +: DB] = 16'hBEEF;
    mem_write_valid[0] = 1'b1;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    total++; if (mem_read_ready !== '0) $display("FAIL abort_read_ready got %b want 0", mem_read_ready); else passed++;
    total++; if (mem_write_ready !== '0) $display("FAIL abort_write_ready got %b want 0", mem_write_ready); else passed++;
    total++; if (mem_read_data !== '0) $display("FAIL abort_read_data got %h want 0", mem_read_data); else passed++;
    tick();
    tick();
    mem_read_valid = '0;
    mem_write_valid = '0;
    reset = 1'b0;
    tick();
    clear_batch();
    b_rd_en[3] = 1'b1; b_rd_addr[3] = 8'h20;
    run_batch(30);
    total++; if (b_rd_got[3] !== 16'h0001) $display("FAIL abort_no_commit got %h want 0001", b_rd_got[3]); else passed++;
  endtask

  task automatic test_write_collision();
    clear_batch();
    b_wr_en[0] = 1'b1; b_wr_addr[0] = 8'h77; b_wr_dat[0] = 16'hC0DE;
    b_wr_en[2] = 1'b1; b_wr_addr[2] = 8'h77; b_wr_dat[2] = 16'hF00D;
    run_batch(30);
    total++; if (!((b_wr_lat[0] == WL + 1 && b_wr_lat[2] == WL + 2) || (b_wr_lat[0] == WL + 2 && b_wr_lat[2] == WL + 1)))
      $display("FAIL collision_lat got %0d,%0d want {%0d,%0d}", b_wr_lat[0], b_wr_lat[2], WL + 1, WL + 2); else passed++;
    commit_model();
    clear_batch();
    b_rd_en[1] = 1'b1; b_rd_addr[1] = 8'h77;
    run_batch(30);
    total++; if (b_rd_got[1] !== model_mem[8'h77])
      $display("FAIL collision_last_wins got %h want %h", b_rd_got[1], model_mem[8'h77]); else passed++;
  endtask

  task automatic test_random();
    logic [DB-1:0] exp_rd [NCH];
    logic [AB-1:0] cand;
    bit clash;
    int cnt;
    for (int it = 0; it < 20; it++) begin
      clear_batch();
      for (int c = 0; c < NCH; c++) begin
        b_wr_en[c]   = 1'($urandom_range(0, 1));
        b_wr_addr[c] = 8'(8'h80 + $urandom_range(0, 7));
        b_wr_dat[c]  = 16'($urandom);
      end
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 1) == 1) begin
          for (int t = 0; t < 4 && !b_rd_en[c]; t++) begin
            cand = known_q[$urandom_range(0, known_q.size() - 1)];
            clash = 1'b0;
            for (int w = 0; w < NCH; w++) if (b_wr_en[w] && b_wr_addr[w] == cand) clash = 1'b1;
            if (!clash) begin
              b_rd_en[c] = 1'b1; b_rd_addr[c] = cand;
            end
          end
        end
        exp_rd[c] = model_mem[b_rd_addr[c]];
      end
      run_batch(40);
      for (int c = 0; c < NCH; c++) begin
        if (b_rd_en[c]) begin
          total++; if (b_rd_got[c] !== exp_rd[c])
            $display("FAIL rand_rd_data it%0d ch%0d got %h want %h", it, c, b_rd_got[c], exp_rd[c]); else passed++;
        end
      end
      // All requests start together, so grants must fill consecutive cycles.
      for (int k = 1; k <= NCH; k++) begin
        int nr, nw;
        nr = 0; nw = 0;
        for (int c = 0; c < NCH; c++) begin
          if (b_rd_en[c]) nr++;
          if (b_wr_en[c]) nw++;
        end
        if (k <= nr) begin
          cnt = 0;
          for (int c = 0; c < NCH; c++) if (b_rd_en[c] && b_rd_lat[c] == RL + k) cnt++;
          total++; if (cnt != 1) $display("FAIL rand_rd_slot it%0d lat%0d got %0d reads want 1", it, RL + k, cnt); else passed++;
        end
        if (k <= nw) begin
          cnt = 0;
          for (int c = 0; c < NCH; c++) if (b_wr_en[c] && b_wr_lat[c] == WL + k) cnt++;
          total++; if (cnt != 1) $display("FAIL rand_wr_slot it%0d lat%0d got %0d writes want 1", it, WL + k, cnt); else passed++;
        end
      end
      commit_model();
    end
    // Read back the whole random write window.
    for (int a = 0; a < 8; a += NCH) begin
      clear_batch();
      for (int c = 0; c < NCH; c++) begin
        b_rd_en[c] = model_known[8'(8'h80 + a + c)];
        b_rd_addr[c] = 8'(8'h80 + a + c);
      end
      run_batch(40);
      for (int c = 0; c < NCH; c++) begin
        if (b_rd_en[c]) begin
          total++; if (b_rd_got[c] !== model_mem[b_rd_addr[c]])
            $display("FAIL rand_final addr %h got %h want %h", b_rd_addr[c], b_rd_got[c], model_mem[b_rd_addr[c]]); else passed++;
        end
      end
    end
  endtask

`ifdef MEM_PERF_EN
  task automatic test_perf();
    do_reset();
    clear_batch();
    for (int c = 0; c < 3; c++) begin
      b_rd_en[c] = 1'b1; b_rd_addr[c] = 8'h05;
    end
    b_wr_en[0] = 1'b1; b_wr_addr[0] = 8'h90; b_wr_dat[0] = 16'h1111;
    b_wr_en[1] = 1'b1; b_wr_addr[1] = 8'h91; b_wr_dat[1] = 16'h2222;
    run_batch(40);
    commit_model();
    total++; if (perf_reads !== 32'd3) $display("FAIL perf_reads got %0d want 3", perf_reads); else passed++;
    total++; if (perf_writes !== 32'd2) $display("FAIL perf_writes got %0d want 2", perf_writes); else passed++;
    do_reset();
    total++; if (perf_reads !== 32'd0 || perf_writes !== 32'd0)
      $display("FAIL perf_cleared got %0d/%0d want 0/0", perf_reads, perf_writes); else passed++;
  endtask
`endif

  initial begin
    for (int a = 0; a < 256; a++) begin
      model_mem[a] = '0;
      model_known[a] = 1'b0;
    end
    test_reset();
    test_single_channel();
    test_parallel_reads();
    test_rw_hazard();
    test_hold();
    test_reset_abort();
    test_write_collision();
    test_random();
`ifdef MEM_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
